// File: rtl/mem_responder_pkg.sv
// Shared types for the memory responder.
// Holds the request-mode and FSM state encodings, data-path widths and the
// latched request payload.
package mem_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic {
    MODE_READ  = 1'b0,
    MODE_WRITE = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Request fields kept for the whole transaction; the word index is held
  // separately because its width depends on the RAM depth.
  typedef struct packed {
    mode_e               mode;
    logic [DATA_W-1:0]   wdata;
    logic [STRB_W-1:0]   wstrb;
  } req_payload_t;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator and mem_responder.
// master: request_enable, req_mode, req_addr, req_wdata, req_wstrb out;
//         response_enable, resp_data, busy, protocol_error in.
// slave : the reverse.
interface mem_responder_if;
  import mem_pkg::*;

  logic              request_enable;
  logic              req_mode;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [STRB_W-1:0] req_wstrb;
  logic              response_enable;
  logic [DATA_W-1:0] resp_data;
  logic              busy;
  logic              protocol_error;

  modport master (
    output request_enable, req_mode, req_addr, req_wdata, req_wstrb,
    input  response_enable, resp_data, busy, protocol_error
  );

  modport slave (
    input  request_enable, req_mode, req_addr, req_wdata, req_wstrb,
    output response_enable, resp_data, busy, protocol_error
  );

endinterface

// File: rtl/mem_responder_ram.sv
// Single-port 2^ADDR_WIDTH x 32 RAM with byte write enables and a
// one-cycle registered read.
// Ports: clk; en (access strobe); we (1 = write); addr (word index);
//        wdata/wstrb (write data, byte enables); rdata (read data, held).
module mem_responder_ram
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [STRB_W-1:0]     wstrb,
  output logic [DATA_W-1:0]     rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is never reset; rdata only changes on a read access.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < int'(STRB_W); i++) begin
          if (wstrb[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: accepts one read/write request at a time,
// performs it on an internal RAM and pulses response_enable LATENCY cycles
// after the accept cycle.
// Ports: clk; rst (synchronous, active-high); bus (slave side of
//        mem_responder_if: request strobe/fields in, response strobe, read
//        data, busy and sticky protocol_error out).
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned LATENCY    = 2
) (
  input  logic          clk,
  input  logic          rst,
  mem_responder_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LATENCY - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  req_payload_t            req_q, in_req, cur_req;
  logic [ADDR_WIDTH-1:0]   word_q, in_word, cur_word;
  logic                    accept;
  logic                    ram_en;
  logic [DATA_W-1:0]       ram_rdata;
  logic [DATA_W-1:0]       resp_now;
  logic [DATA_W-1:0]       resp_hold_q;
  logic                    response_enable_q;
  logic                    busy_q;
  logic                    protocol_error_q;

  // busy is low exactly in IDLE, so IDLE alone qualifies an accept.
  assign accept = bus.request_enable && (state_q == IDLE);

  // Shift-then-truncate drops the byte offset and aliases upper address bits.
  assign in_word = ADDR_WIDTH'(bus.req_addr >> 2);

  // Next state and latency counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d = CNT_W'(1);
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == LAST_CNT) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // RAM request source: live bus fields in IDLE (LATENCY=1 accesses the RAM
  // on the accept edge), otherwise the latched request.
  always_comb begin
    in_req.mode  = mode_e'(bus.req_mode);
    in_req.wdata = bus.req_wdata;
    in_req.wstrb = bus.req_wstrb;
    cur_req      = req_q;
    cur_word     = word_q;
    if (state_q == IDLE) begin
      cur_req  = in_req;
      cur_word = in_word;
    end
  end

  // Access the RAM only on the edge entering RESP, so a reset while waiting
  // drops a pending write and the read data lands in the response cycle.
  assign ram_en = (state_d == RESP) && !rst;

  mem_responder_ram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (cur_req.mode == MODE_WRITE),
    .addr  (cur_word),
    .wdata (cur_req.wdata),
    .wstrb (cur_req.wstrb),
    .rdata (ram_rdata)
  );

  assign resp_now = (req_q.mode == MODE_READ) ? ram_rdata : '0;

  // State, request latch and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= IDLE;
      cnt_q             <= '0;
      req_q             <= '0;
      word_q            <= '0;
      response_enable_q <= 1'b0;
      busy_q            <= 1'b0;
      protocol_error_q  <= 1'b0;
      resp_hold_q       <= '0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      response_enable_q <= (state_d == RESP);
      busy_q            <= (state_d != IDLE);
      if (accept) begin
        req_q  <= in_req;
        word_q <= in_word;
      end
      if (bus.request_enable && (state_q != IDLE)) begin
        protocol_error_q <= 1'b1;
      end
      if (state_q == RESP) begin
        resp_hold_q <= resp_now;
      end
    end
  end

  // resp_data shows the RAM output during RESP and holds it afterwards.
  assign bus.resp_data       = (state_q == RESP) ? resp_now : resp_hold_q;
  assign bus.response_enable = response_enable_q;
  assign bus.busy            = busy_q;
  assign bus.protocol_error  = protocol_error_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14, meaning word-address bits (RAM depth 2^ADDR_WIDTH 32-bit words).
REQ-002 SHALL have parameter LATENCY, default 2, meaning cycles from request accept to response pulse; legal range 1..15.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port request_enable, input, 1, one-cycle request strobe from the initiator.
REQ-006 SHALL have port req_mode, input, 1, 0 = read, 1 = write.
REQ-007 SHALL have port req_addr, input, 32, byte address.
REQ-008 SHALL have port req_wdata, input, 32, write data.
REQ-009 SHALL have port req_wstrb, input, 4, byte enables, bit i for bits 8i+7:8i.
REQ-010 SHALL have port response_enable, output, 1, one-cycle completion strobe.
REQ-011 SHALL have port resp_data, output, 32, read data.
REQ-012 SHALL have port busy, output, 1, high while a request is outstanding.
REQ-013 SHALL have port protocol_error, output, 1, sticky flag for a request received while busy.

Function
REQ-014 SHALL sample req_mode/req_addr/req_wdata/req_wstrb only in the cycle request_enable=1 and busy=0 (accept cycle).
REQ-015 SHALL implement states IDLE, WAIT, RESP: IDLE -> WAIT on accept when LATENCY>1, IDLE -> RESP on accept when LATENCY=1, WAIT -> RESP when latency counter reaches LATENCY-1, RESP -> IDLE unconditionally.
REQ-016 SHALL assert response_enable for exactly one cycle, in RESP, exactly LATENCY cycles after the accept cycle.
REQ-017 SHALL drive busy=1 in WAIT and RESP and busy=0 in IDLE; a new request is accepted in the cycle after RESP at earliest.
REQ-018 SHALL use word index req_addr[ADDR_WIDTH+1:2]; bits [1:0] and bits above ADDR_WIDTH+1 ignored (aliasing).
REQ-019 SHALL, on write, update only strobed bytes of the addressed word, committed no later than the response cycle; req_wstrb=0 writes nothing but still responds.
REQ-020 SHALL, on read, present the full addressed word on resp_data during the response cycle; resp_data value in other cycles unspecified but stable (held).
REQ-021 SHALL drive resp_data=0 in the response cycle of a write.
REQ-022 SHALL give a read accepted after a write response the written data (no stale read).
REQ-023 SHALL ignore request_enable while busy=1, causing no state or memory change, and set protocol_error=1 until reset.
REQ-024 SHALL treat request_enable during the RESP cycle as a request while busy (REQ-023).

Reset
REQ-025 SHALL, when rst=1 at a rising edge, enter IDLE and clear counter, response_enable=0, busy=0, protocol_error=0, resp_data=0.
REQ-026 SHALL, on reset mid-operation, discard the outstanding request: no response pulse; a pending write not yet committed is dropped.
REQ-027 SHALL not clear RAM contents on reset.
REQ-028 SHALL ignore request_enable in a cycle where rst=1.

Structure
REQ-029 SHALL place mode encodings (MODE_READ=0, MODE_WRITE=1) and state encodings in shared package mem_pkg.
REQ-030 SHALL instantiate one sub-module mem_responder_ram: single-port 2^ADDR_WIDTH x 32 RAM, byte-write enables, one-cycle registered read.

Verification
REQ-031 SHALL cover: LATENCY=2, write 0xDEADBEEF wstrb=0xF addr 0x10, then read 0x10 -> response 2 cycles after each accept, read resp_data=0xDEADBEEF.
REQ-032 SHALL cover: after REQ-031, write 0x000000AA wstrb=0x1 addr 0x13, read 0x10 -> resp_data=0xDEADBEAA.
REQ-033 SHALL cover: read accepted, second request_enable one cycle later -> single response, memory unchanged, protocol_error=1 held until rst.
REQ-034 SHALL cover: LATENCY=1, back-to-back read requests every 2 cycles -> each accepted, response_enable every 2nd cycle, busy toggles.
REQ-035 SHALL cover: write 0x12345678 addr 0x20, rst=1 in WAIT -> no response_enable, busy=0 next cycle, subsequent read 0x20 returns prior contents.
REQ-036 SHALL cover: ADDR_WIDTH=4, write 0x55 to addr 0x04, read addr 0x44 -> resp_data=0x00000055 (aliasing).
